// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage drives req/addr and imem answers with ready/rdata.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, fetches over a
// req/ready handshake and honours decode's stall, redirect and halt.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is_hazard_detected,
  input  logic                   program_flow_change_taken,
  input  logic [31:0]            new_PC,
  input  logic                   halted,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            inst,
  output logic [31:0]            PC,
  output logic                   inst_valid
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_d, pc_out_d;
  logic        valid_d;
  logic [31:0] skid_inst_q, skid_pc_q;
  logic        skid_load;
  logic [31:0] redir_q, redir_d;
  logic        halt_pend_q, halt_pend_d;
  logic        flush;
  logic        ready;

  assign imem.imem_req  = !rst && (state_q == S_FETCH || state_q == S_DROP);
  assign imem.imem_addr = pc_q;
  assign ready          = imem.imem_ready && imem.imem_req;

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst;
    pc_out_d    = PC;
    valid_d     = inst_valid;
    skid_load   = 1'b0;
    redir_d     = redir_q;
    halt_pend_d = halt_pend_q;
    flush       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (is_hazard_detected) begin
          if (ready) begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (halted) begin
          flush = 1'b1;
          if (ready) begin
            state_d = S_HALT;
          end else begin
            halt_pend_d = 1'b1;
            state_d     = S_DROP;
          end
        end else if (program_flow_change_taken) begin
          flush = 1'b1;
          if (ready) begin
            pc_d = new_PC;
          end else begin
            redir_d = new_PC;
            state_d = S_DROP;
          end
        end else if (ready) begin
          inst_d   = imem.imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_STEP;
        end else begin
          // Decode consumed the old entry; with no new word it must see a bubble.
          flush = 1'b1;
        end
      end

      S_HOLD: begin
        if (!is_hazard_detected) begin
          state_d = S_FETCH;
          if (halted) begin
            flush   = 1'b1;
            state_d = S_HALT;
          end else if (program_flow_change_taken) begin
            flush = 1'b1;
            pc_d  = new_PC;
          end else begin
            inst_d   = skid_inst_q;
            pc_out_d = skid_pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_STEP;
          end
        end
      end

      S_DROP: begin
        flush = 1'b1;
        if (!is_hazard_detected && halted)                    halt_pend_d = 1'b1;
        if (!is_hazard_detected && program_flow_change_taken) redir_d     = new_PC;
        // The orphaned request must complete before the new target can be issued.
        if (ready) begin
          if (halt_pend_d) begin
            state_d = S_HALT;
          end else begin
            pc_d    = redir_d;
            state_d = S_FETCH;
          end
        end
      end

      S_HALT: flush = 1'b1;

      default: state_d = S_FETCH;
    endcase

    if (flush) begin
      inst_d   = 32'h0;
      pc_out_d = 32'h0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      inst        <= 32'h0;
      PC          <= 32'h0;
      inst_valid  <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst        <= inst_d;
      PC          <= pc_out_d;
      inst_valid  <= valid_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // NOTE: skid and redirect-target registers are only read after being written, so they skip reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_inst_q <= imem.imem_rdata;
      skid_pc_q   <= pc_q;
    end
    redir_q <= redir_d;
  end

endmodule
